// File: rtl/dkong_sound_pkg.sv
// Shared types and constants for the Donkey Kong sound command scheduler.
package dkong_sound_pkg;

  localparam int SFX_COUNT = 6;
  localparam int BG_W      = 4;
  localparam int CNT_W     = 20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BG_IRQ   = 2'd1,
    ST_SFX_HOLD = 2'd2,
    ST_GAP      = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic            sfx;
    logic [BG_W-1:0] data;
  } sound_cmd_t;

  // Active-low one-hot trigger pattern for an effect index.
  function automatic logic [SFX_COUNT-1:0] sfx_low_mask(input logic [BG_W-1:0] idx);
    logic [SFX_COUNT-1:0] m;
    for (int i = 0; i < SFX_COUNT; i++) begin
      m[i] = (idx == BG_W'(i)) ? 1'b0 : 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sound_cmd_fifo.sv
// Small synchronous FIFO of sound commands; push is ignored when full, pop when empty.
module sound_cmd_fifo
  import dkong_sound_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  sound_cmd_t             din,
  input  logic                   pop,
  output sound_cmd_t             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sound_cmd_fifo: DEPTH must be a power of 2 and at least 2");
  end

  sound_cmd_t    mem_q [DEPTH];
  sound_cmd_t    mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == (AW+1)'(0));
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end else begin
      wr_d = wr_q;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end else begin
      rd_d = rd_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= sound_cmd_t'(0);
      end
      wr_q  <= AW'(0);
      rd_q  <= AW'(0);
      cnt_q <= (AW+1)'(0);
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dkong_sound_sched.sv
// Schedules queued tune/effect requests onto dkong_sound's active-low ports.
// Optional DKSND_SFX_RETRIGGER_EN: a matching effect at the head extends the current hold.
module dkong_sound_sched
  import dkong_sound_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 61440,
  parameter int GAP_CYCLES  = 6144,
  parameter int ACK_TIMEOUT = 1048575
) (
  input  logic                 masterclk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_sfx,
  input  logic [BG_W-1:0]      cmd_data,
  output logic [BG_W-1:0]      bg_port,
  output logic [SFX_COUNT-1:0] sfx_port,
  output logic                 audio_irq,
  input  logic                 audio_ack,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_badsfx
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int FW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX || GAP_CYCLES < 1 || GAP_CYCLES > CNT_MAX ||
      ACK_TIMEOUT < 1 || ACK_TIMEOUT > CNT_MAX) begin : g_bad_param
    $error("dkong_sound_sched: cycle parameters must lie in 1..2^20-1");
  end

  sched_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BG_W-1:0]      bg_q, bg_d;
  logic [SFX_COUNT-1:0] sfx_q, sfx_d;
  logic                 irq_q, irq_d, errt_q, errt_d, errb_q, errb_d;
`ifdef DKSND_SFX_RETRIGGER_EN
  logic [BG_W-1:0]      idx_q, idx_d;
`endif

  sound_cmd_t    push_cmd, head;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_count;

  assign push_cmd = sound_cmd_t'({cmd_sfx, cmd_data});

  sound_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (masterclk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   (push_cmd),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_ready   = !fifo_full;
  assign busy        = (state_q != ST_IDLE) || (fifo_count != FW'(0));
  assign bg_port     = bg_q;
  assign sfx_port    = sfx_q;
  assign audio_irq   = irq_q;
  assign err_timeout = errt_q;
  assign err_badsfx  = errb_q;

  // Next-state, counter and port logic; ack beats timeout on the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
    bg_d     = bg_q;
    sfx_d    = sfx_q;
    irq_d    = irq_q;
    errt_d   = errt_q;
    errb_d   = errb_q;
    fifo_pop = 1'b0;
`ifdef DKSND_SFX_RETRIGGER_EN
    idx_d    = idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_W'(0);
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!head.sfx) begin
            bg_d    = ~head.data;
            irq_d   = 1'b0;
            state_d = ST_BG_IRQ;
          end else if (head.data < BG_W'(SFX_COUNT)) begin
            sfx_d   = sfx_low_mask(head.data);
            state_d = ST_SFX_HOLD;
`ifdef DKSND_SFX_RETRIGGER_EN
            idx_d   = head.data;
`endif
          end else begin
            errb_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BG_IRQ: begin
        if (audio_ack) begin
          irq_d   = 1'b1;
          cnt_d   = CNT_W'(0);
          state_d = ST_GAP;
        end else if (cnt_q == ACK_LAST) begin
          irq_d   = 1'b1;
          errt_d  = 1'b1;
          cnt_d   = CNT_W'(0);
          state_d = ST_GAP;
        end else begin
          state_d = ST_BG_IRQ;
        end
      end
      ST_SFX_HOLD: begin
`ifdef DKSND_SFX_RETRIGGER_EN
        if (!fifo_empty && head.sfx && head.data == idx_q) begin
          fifo_pop = 1'b1;
          cnt_d    = CNT_W'(0);
        end else
`endif
        if (cnt_q == HOLD_LAST) begin
          sfx_d   = {SFX_COUNT{1'b1}};
          cnt_d   = CNT_W'(0);
          state_d = ST_GAP;
        end else begin
          state_d = ST_SFX_HOLD;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = CNT_W'(0);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase
  end

  // State, counter and output registers; reset releases every port at once.
  always_ff @(posedge masterclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_W'(0);
      bg_q    <= {BG_W{1'b1}};
      sfx_q   <= {SFX_COUNT{1'b1}};
      irq_q   <= 1'b1;
      errt_q  <= 1'b0;
      errb_q  <= 1'b0;
`ifdef DKSND_SFX_RETRIGGER_EN
      idx_q   <= BG_W'(0);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bg_q    <= bg_d;
      sfx_q   <= sfx_d;
      irq_q   <= irq_d;
      errt_q  <= errt_d;
      errb_q  <= errb_d;
`ifdef DKSND_SFX_RETRIGGER_EN
      idx_q   <= idx_d;
`endif
    end
  end

endmodule
